// File: rtl/vga_rect_pkg.sv
// Shared types and register-map constants for the VGA rectangle overlay engine.
package vga_rect_pkg;

    localparam int MAX_COORD_W = 16;
    localparam int MAX_COLOR_W = 31;

    localparam logic [31:0] CTRL_OFS    = 32'h00;
    localparam logic [31:0] RECT_BASE   = 32'h10;
    localparam logic [31:0] RECT_STRIDE = 32'h10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [MAX_COORD_W-1:0] x0;
        logic [MAX_COORD_W-1:0] y0;
        logic [MAX_COORD_W-1:0] x1;
        logic [MAX_COORD_W-1:0] y1;
        logic [MAX_COLOR_W-1:0] color;
        logic                   en;
    } rect_t;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_rect_hit.sv
// Registered inclusive bounds compare for one rectangle descriptor.
module vga_rect_hit
    import vga_rect_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MAX_COORD_W-1:0] x,
    input  logic [MAX_COORD_W-1:0] y,
    input  logic [MAX_COORD_W-1:0] x0,
    input  logic [MAX_COORD_W-1:0] y0,
    input  logic [MAX_COORD_W-1:0] x1,
    input  logic [MAX_COORD_W-1:0] y1,
    input  logic                   en,
    output logic                   hit
);

    logic in_x;
    logic in_y;

    // Inverted corners fail one of the two compares, so they never hit.
    assign in_x = (x >= x0) && (x <= x1);
    assign in_y = (y >= y0) && (y <= y1);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit <= 1'b0;
        end else begin
            hit <= en && in_x && in_y;
        end
    end

endmodule

// File: rtl/vga_rect_engine.sv
// AXI4-Lite programmable rectangle overlay with 2-cycle pixel pipeline.
// Define VGA_RECT_SHADOW_EN for frame-synchronous double-buffered descriptors.
module vga_rect_engine
    import vga_rect_pkg::*;
#(
    parameter int NUM_RECTS          = 4,
    parameter int COORD_W            = 10,
    parameter int COLOR_W            = 12,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic                          frame_start,
    input  logic [COORD_W-1:0]            pix_x,
    input  logic [COORD_W-1:0]            pix_y,
    input  logic                          pix_valid,
    output logic [COLOR_W-1:0]            pix_color,
    output logic                          pix_hit,
    output logic                          pix_out_valid
);

    localparam logic [MAX_COORD_W-1:0] CMASK =
        MAX_COORD_W'((33'd1 << COORD_W) - 33'd1);
    localparam logic [MAX_COLOR_W-1:0] KMASK =
        MAX_COLOR_W'((33'd1 << COLOR_W) - 33'd1);
    localparam logic [31:0] RECT_END =
        RECT_BASE + 32'(NUM_RECTS) * RECT_STRIDE;

    rect_t stg [NUM_RECTS];
    rect_t act [NUM_RECTS];

    logic awready, bvalid, arready, rvalid;
    logic [31:0] rdata;
    logic gen, pending;

    logic [31:0] w_a, r_a, w_idx, r_idx;
    logic w_ctrl, w_rect, r_ctrl, r_rect, wr_fire;
    logic [31:0] w_old, w_new, r_val;

    function automatic logic [31:0] word_of(input rect_t r, input logic [1:0] w);
        logic [31:0] v;
        v = '0;
        case (w)
            2'd0:    v = {r.y0, r.x0};
            2'd1:    v = {r.y1, r.x1};
            2'd2:    v = {r.en, r.color};
            default: v = '0;
        endcase
        return v;
    endfunction

    assign w_a    = 32'(S_AXI_AWADDR);
    assign r_a    = 32'(S_AXI_ARADDR);
    assign w_ctrl = (w_a & ~32'h3) == CTRL_OFS;
    assign r_ctrl = (r_a & ~32'h3) == CTRL_OFS;
    assign w_rect = (w_a >= RECT_BASE) && (w_a < RECT_END);
    assign r_rect = (r_a >= RECT_BASE) && (r_a < RECT_END);
    assign w_idx  = (w_a - RECT_BASE) / RECT_STRIDE;
    assign r_idx  = (r_a - RECT_BASE) / RECT_STRIDE;

    assign wr_fire = awready && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_new   = strb_merge(w_old, S_AXI_WDATA, S_AXI_WSTRB);

    always_comb begin
        w_old = '0;
        r_val = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            if (w_rect && w_idx == 32'(i)) w_old = word_of(stg[i], w_a[3:2]);
            if (r_rect && r_idx == 32'(i)) r_val = word_of(stg[i], r_a[3:2]);
        end
        if (r_ctrl) r_val = {30'd0, pending, gen};
    end

    // Write channel: address and data accepted together, one in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready <= 1'b0;
            bvalid  <= 1'b0;
            gen     <= 1'b0;
            for (int i = 0; i < NUM_RECTS; i++) stg[i] <= '0;
        end else begin
            awready <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid && !awready;
            if (wr_fire) bvalid <= 1'b1;
            else if (S_AXI_BREADY) bvalid <= 1'b0;
            if (wr_fire && w_ctrl && S_AXI_WSTRB[0]) gen <= S_AXI_WDATA[0];
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (wr_fire && w_rect && w_idx == 32'(i)) begin
                    case (w_a[3:2])
                        2'd0: begin
                            stg[i].x0 <= w_new[15:0] & CMASK;
                            stg[i].y0 <= w_new[31:16] & CMASK;
                        end
                        2'd1: begin
                            stg[i].x1 <= w_new[15:0] & CMASK;
                            stg[i].y1 <= w_new[31:16] & CMASK;
                        end
                        2'd2: begin
                            stg[i].color <= w_new[30:0] & KMASK;
                            stg[i].en    <= w_new[31];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            arready <= S_AXI_ARVALID && !rvalid && !arready;
            if (arready && S_AXI_ARVALID) begin
                rvalid <= 1'b1;
                rdata  <= r_val;
            end else if (S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

`ifdef VGA_RECT_SHADOW_EN
    logic commit_wr;
    assign commit_wr = wr_fire && w_ctrl && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

    // Copy uses pre-edge staging, so a same-cycle write waits a frame.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pending <= 1'b0;
            for (int i = 0; i < NUM_RECTS; i++) act[i] <= '0;
        end else begin
            if (commit_wr) pending <= 1'b1;
            else if (frame_start && pending) pending <= 1'b0;
            if (frame_start && pending) begin
                for (int i = 0; i < NUM_RECTS; i++) act[i] <= stg[i];
            end
        end
    end
`else
    logic unused_fs;
    assign unused_fs = frame_start;
    assign pending = 1'b0;
    assign act = stg;
`endif

    logic [NUM_RECTS-1:0] hit_vec;
    logic [COLOR_W-1:0]   sel;
    logic                 v1;

    for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
        vga_rect_hit u_hit (
            .clk (ACLK),
            .rst (ARESET),
            .x   (MAX_COORD_W'(pix_x)),
            .y   (MAX_COORD_W'(pix_y)),
            .x0  (act[g].x0),
            .y0  (act[g].y0),
            .x1  (act[g].x1),
            .y1  (act[g].y1),
            .en  (act[g].en),
            .hit (hit_vec[g])
        );
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (hit_vec[i]) sel = act[i].color[COLOR_W-1:0];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            v1            <= 1'b0;
            pix_out_valid <= 1'b0;
            pix_hit       <= 1'b0;
            pix_color     <= '0;
        end else begin
            v1            <= pix_valid;
            pix_out_valid <= v1;
            pix_hit       <= gen && (|hit_vec);
            pix_color     <= gen ? sel : '0;
        end
    end

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = awready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_vga_rect_engine.sv
// Directed plus randomized bench for vga_rect_engine with a register-level model.
module tb_vga_rect_engine;

    localparam int NR = 4;
    localparam int CW = 10;
    localparam int KW = 12;
    localparam int AW = 7;
`ifdef VGA_RECT_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0] S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
    logic S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0] S_AXI_WSTRB = '0;
    logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic frame_start = 0, pix_valid = 0;
    logic [CW-1:0] pix_x = '0, pix_y = '0;
    logic [KW-1:0] pix_color;
    logic pix_hit, pix_out_valid;

    vga_rect_engine #(
        .NUM_RECTS(NR), .COORD_W(CW), .COLOR_W(KW), .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .pix_color(pix_color), .pix_hit(pix_hit),
        .pix_out_valid(pix_out_valid)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0, passes = 0, fails = 0;
    logic [31:0] m_stg [32];
    logic [31:0] m_act [32];
    logic m_gen = 0, m_pend = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Writable bits of each word, straight from the register map.
    function automatic logic [31:0] wmask(input int w);
        if (w >= 4 && w < 4 + 4 * NR) begin
            if (w % 4 == 2) return 32'h80000FFF;
            if (w % 4 == 3) return 32'h0;
            return 32'h03FF03FF;
        end
        return 32'h0;
    endfunction

    task automatic m_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        logic [31:0] bm, mk;
        w = int'(a) / 4;
        for (int b = 0; b < 4; b++) bm[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
        if (w == 0) begin
            if (s[0]) begin
                m_gen = d[0];
                if (SHADOW && d[1]) m_pend = 1'b1;
            end
        end else begin
            mk = wmask(w) & bm;
            m_stg[w] = (m_stg[w] & ~mk) | (d & mk);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [AW-1:0] a);
        int w;
        w = int'(a) / 4;
        if (w == 0) return {30'd0, m_pend, m_gen};
        return m_stg[w];
    endfunction

    task automatic m_frame();
        if (SHADOW && m_pend) begin
            m_act = m_stg;
            m_pend = 1'b0;
        end
    endtask

    task automatic m_pix(input int x, input int y, output logic h, output logic [KW-1:0] c);
        logic [31:0] w0, w1, w2;
        int x0, y0, x1, y1;
        h = 1'b0;
        c = '0;
        if (!m_gen) return;
        for (int r = 0; r < NR; r++) begin
            w0 = SHADOW ? m_act[4+4*r] : m_stg[4+4*r];
            w1 = SHADOW ? m_act[5+4*r] : m_stg[5+4*r];
            w2 = SHADOW ? m_act[6+4*r] : m_stg[6+4*r];
            x0 = int'(w0 % 1024); y0 = int'(w0 / 65536);
            x1 = int'(w1 % 1024); y1 = int'(w1 / 65536);
            if (w2[31] && x >= x0 && x <= x1 && y >= y0 && y <= y1) begin
                h = 1'b1;
                c = w2[KW-1:0];
                return;
            end
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit fs);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) break;
        end
        check("aw_w_ready", {31'd0, S_AXI_AWREADY && S_AXI_WREADY}, 32'd1);
        frame_start = fs;
        @(posedge ACLK);
        if (fs) m_frame();
        m_write(a, d, s);
        #1;
        frame_start = 0;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        check("awready_pulse", {31'd0, S_AXI_AWREADY}, 32'd0);
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) break;
        end
        check("bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        check("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        S_AXI_BREADY = 1;
        @(posedge ACLK);
        #1;
        S_AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
        S_AXI_ARADDR = a;
        S_AXI_ARVALID = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) break;
        end
        check("arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) break;
        end
        check("rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        d = S_AXI_RDATA;
        S_AXI_RREADY = 1;
        @(posedge ACLK);
        #1;
        S_AXI_RREADY = 0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic pulse_frame();
        frame_start = 1;
        @(posedge ACLK);
        m_frame();
        #1;
        frame_start = 0;
    endtask

    task automatic pix_check(input string tag, input int x, input int y,
                             input logic h, input logic [KW-1:0] c);
        pix_x = CW'(x); pix_y = CW'(y); pix_valid = 1;
        @(posedge ACLK);
        #1;
        pix_valid = 0;
        check({tag, "_lat1"}, {31'd0, pix_out_valid}, 32'd0);
        @(posedge ACLK);
        #1;
        check({tag, "_valid"}, {31'd0, pix_out_valid}, 32'd1);
        check({tag, "_hit"}, {31'd0, pix_hit}, {31'd0, h});
        check({tag, "_color"}, {20'd0, pix_color}, {20'd0, c});
    endtask

    task automatic pix_model(input string tag, input int x, input int y);
        logic h;
        logic [KW-1:0] c;
        m_pix(x, y, h, c);
        pix_check(tag, x, y, h, c);
    endtask

    task automatic readback_all(input string tag);
        for (int a = 0; a < 128; a += 4) read_check(tag, AW'(a), m_read(AW'(a)));
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0] s;
        for (int i = 0; i < 32; i++) begin
            m_stg[i] = '0;
            m_act[i] = '0;
        end
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_pix", {18'd0, pix_out_valid, pix_hit, pix_color}, 32'd0);
        check("rst_axi", {28'd0, S_AXI_AWREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}, 32'd0);
        ARESET = 0;
        readback_all("rst_read");

        axi_write(7'h10, 32'h000A000A, 4'hF, 0);
        axi_write(7'h14, 32'h00140014, 4'hF, 0);
        axi_write(7'h18, 32'h80000F00, 4'hF, 0);
        axi_write(7'h00, 32'h3, 4'hF, 0);
        pulse_frame();
        pix_check("p10_10", 10, 10, 1'b1, 12'hF00);
        pix_check("p20_20", 20, 20, 1'b1, 12'hF00);
        pix_check("p21_20", 21, 20, 1'b0, 12'h000);

        axi_write(7'h20, 32'h00000000, 4'hF, 0);
        axi_write(7'h24, 32'h00640064, 4'hF, 0);
        axi_write(7'h28, 32'h800000F0, 4'hF, 0);
        axi_write(7'h00, 32'h3, 4'hF, 0);
        pulse_frame();
        pix_check("ovl15", 15, 15, 1'b1, 12'hF00);
        pix_check("ovl50", 50, 50, 1'b1, 12'h0F0);

        axi_write(7'h18, 32'h8000000F, 4'hF, 0);
        pulse_frame();
        pix_check("shadow_hold", 15, 15, 1'b1, SHADOW ? 12'hF00 : 12'h00F);
        read_check("shadow_rd", 7'h18, 32'h8000000F);
        axi_write(7'h00, 32'h3, 4'hF, 0);
        pulse_frame();
        pix_check("shadow_commit", 15, 15, 1'b1, 12'h00F);

        axi_write(7'h18, 32'h80000ABC, 4'hF, 0);
        axi_write(7'h00, 32'h3, 4'hF, 1);
        pix_check("same_cyc", 15, 15, 1'b1, SHADOW ? 12'h00F : 12'hABC);
        read_check("same_cyc_ctrl", 7'h00, SHADOW ? 32'h3 : 32'h1);
        pulse_frame();
        pix_check("next_frame", 15, 15, 1'b1, 12'hABC);
        read_check("ctrl_cleared", 7'h00, 32'h1);

        axi_write(7'h14, 32'hFFFFFFFF, 4'b0001, 0);
        read_check("wstrb", 7'h14, 32'h001400FF);
        axi_write(7'h7C, 32'hFFFFFFFF, 4'hF, 0);
        readback_all("oor_read");

        // Randomized descriptor sets, including inverted corners and GEN off.
        for (int rnd = 0; rnd < 6; rnd++) begin
            for (int r = 0; r < NR; r++) begin
                for (int w = 0; w < 3; w++) begin
                    d = $urandom;
                    if (w < 2) begin
                        d[9:0] = 10'($urandom_range(0, 63));
                        d[25:16] = 10'($urandom_range(0, 63));
                    end
                    s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                    axi_write(AW'(16 + 16 * r + 4 * w), d, s, 0);
                end
            end
            axi_write(7'h00, {30'd0, 1'b1, rnd != 2}, 4'hF, 0);
            pulse_frame();
            for (int p = 0; p < 8; p++) begin
                pix_model("rand_pix", $urandom_range(0, 70), $urandom_range(0, 70));
            end
            readback_all("rand_read");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
